pipe_reg: RTL and testbench

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg.sv | 83 ++++++++
 tb/tb_pipe_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// pipe_reg: elastic register pipeline of DEPTH stages with valid/ready handshake.
// Each stage advances whenever some stage at or after it can make room, so
// bubbles collapse and a full pipeline still moves one word per cycle.
module pipe_reg #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // Per-stage valid bits and data registers; stage 0 is the input side.
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    // Stage ready, and the valid/data each stage would load when it moves.
    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] pv;
    logic [WIDTH-1:0] pd [DEPTH];

    logic [CNT_W-1:0] cnt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // Unrolled form of r[i] = ~v[i] | r[i+1]: a stage can move unless it
        // and every stage after it are full while the consumer stalls.
        assign r[i] = out_ready | ~(&v[DEPTH-1:i]);

        if (i == 0) begin : g_head
            assign pv[i] = in_valid & ~flush;
            assign pd[i] = in_data;
        end else begin : g_body
            assign pv[i] = v[i-1];
            assign pd[i] = d[i-1];
        end
    end

    // Stage registers: reset beats flush beats normal movement; data only
    // loads behind a valid word so bubbles leave held data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RST_VAL;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r[i]) begin
                    v[i] <= pv[i];
                    if (pv[i]) begin
                        d[i] <= pd[i];
                    end
                end
            end
        end
    end

    // Population count of the registered valid bits.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
    end

    assign in_ready  = r[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign count     = cnt;

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: scenario tasks for pipe_reg (WIDTH=8, DEPTH=4, RST_VAL=0)
// with a queue scoreboard of accepted words.
module tb_pipe_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] count;

    logic [7:0] sb [$];
    int cmp_cnt  = 0;
    int fail_cnt = 0;

    pipe_reg #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    // One clock: sample handshakes mid-cycle, record accepted words, advance.
    task automatic tick(output logic took, output logic [7:0] od);
        #1;
        took = out_valid & out_ready;
        od   = out_data;
        if (in_valid && in_ready && !rst) sb.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic took; logic [7:0] od;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(took, od);
        tick(took, od);
        cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        cmp_cnt++; if (out_data !== 8'h00) begin fail_cnt++; $display("FAIL rst_out_data got=%h want=00", out_data); end
        cmp_cnt++; if (count !== 3'd0) begin fail_cnt++; $display("FAIL rst_count got=%0d want=0", count); end
        cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL rst_in_ready_during got=%b want=1", in_ready); end
        rst = 1'b0;
        #1;
        cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL rst_in_ready_after got=%b want=1", in_ready); end
        sb.delete();
    endtask

    task automatic test_single();
        logic took; logic [7:0] od; logic [7:0] exp;
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        tick(took, od);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cmp_cnt++; if (count !== 3'd1) begin fail_cnt++; $display("FAIL single_count c=%0d got=%0d want=1", c, count); end
            cmp_cnt++; if (out_valid !== (c == 3)) begin fail_cnt++; $display("FAIL single_out_valid c=%0d got=%b want=%b", c, out_valid, (c == 3)); end
            tick(took, od);
            if (took) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                cmp_cnt++; if (od !== exp) begin fail_cnt++; $display("FAIL single_data got=%h want=%h", od, exp); end
            end
        end
        cmp_cnt++; if (count !== 3'd0) begin fail_cnt++; $display("FAIL single_count_end got=%0d want=0", count); end
        cmp_cnt++; if (sb.size() != 0) begin fail_cnt++; $display("FAIL single_drained left=%0d want=0", sb.size()); end
    endtask

    task automatic test_stream();
        logic took; logic [7:0] od; logic [7:0] exp;
        int nout = 0; int first = -1; int last = -1; int cyc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1);
            #1;
            cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL stream_in_ready i=%0d got=%b want=1", i, in_ready); end
            tick(took, od);
            if (took) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                cmp_cnt++; if (od !== exp) begin fail_cnt++; $display("FAIL stream_data got=%h want=%h", od, exp); end
                nout++; if (first < 0) first = cyc; last = cyc;
            end
            cyc++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 12 && sb.size() > 0; k++) begin
            tick(took, od);
            if (took) begin
                exp = sb.pop_front();
                cmp_cnt++; if (od !== exp) begin fail_cnt++; $display("FAIL stream_data got=%h want=%h", od, exp); end
                nout++; if (first < 0) first = cyc; last = cyc;
            end
            cyc++;
        end
        cmp_cnt++; if (nout != 10) begin fail_cnt++; $display("FAIL stream_nout got=%0d want=10", nout); end
        cmp_cnt++; if (last - first != 9) begin fail_cnt++; $display("FAIL stream_span got=%0d want=9", last - first); end
    endtask

    task automatic test_backpressure();
        logic took; logic [7:0] od; logic [7:0] exp;
        int idx = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h20 + idx);
            #1;
            if (in_ready) idx++;
            tick(took, od);
            if (i >= 3) begin
                cmp_cnt++; if (out_data !== 8'h20) begin fail_cnt++; $display("FAIL bp_hold i=%0d got=%h want=20", i, out_data); end
            end
        end
        cmp_cnt++; if (sb.size() != 4) begin fail_cnt++; $display("FAIL bp_accepted got=%0d want=4", sb.size()); end
        cmp_cnt++; if (in_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        cmp_cnt++; if (count !== 3'd4) begin fail_cnt++; $display("FAIL bp_count got=%0d want=4", count); end
        cmp_cnt++; if (out_valid !== 1'b1) begin fail_cnt++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL bp_in_ready_back got=%b want=1", in_ready); end
        for (int k = 0; k < 8 && sb.size() > 0; k++) begin
            tick(took, od);
            if (took) begin
                exp = sb.pop_front();
                cmp_cnt++; if (od !== exp) begin fail_cnt++; $display("FAIL bp_data got=%h want=%h", od, exp); end
            end
        end
        cmp_cnt++; if (sb.size() != 0) begin fail_cnt++; $display("FAIL bp_drained left=%0d want=0", sb.size()); end
    endtask

    task automatic test_full_thru();
        logic took; logic [7:0] od; logic [7:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h30 + i);
            tick(took, od);
        end
        cmp_cnt++; if (count !== 3'd4) begin fail_cnt++; $display("FAIL full_count_pre got=%0d want=4", count); end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h34;
        #1;
        cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL full_in_ready got=%b want=1", in_ready); end
        tick(took, od);
        cmp_cnt++; if (took !== 1'b1) begin fail_cnt++; $display("FAIL full_took got=%b want=1", took); end
        if (took) begin
            exp = sb.pop_front();
            cmp_cnt++; if (od !== exp) begin fail_cnt++; $display("FAIL full_data got=%h want=%h", od, exp); end
        end
        cmp_cnt++; if (count !== 3'd4) begin fail_cnt++; $display("FAIL full_count_post got=%0d want=4", count); end
        in_valid = 1'b0;
        for (int k = 0; k < 8 && sb.size() > 0; k++) begin
            tick(took, od);
            if (took) begin
                exp = sb.pop_front();
                cmp_cnt++; if (od !== exp) begin fail_cnt++; $display("FAIL full_data got=%h want=%h", od, exp); end
            end
        end
        cmp_cnt++; if (sb.size() != 0) begin fail_cnt++; $display("FAIL full_drained left=%0d want=0", sb.size()); end
    endtask

    task automatic test_flush();
        logic took; logic [7:0] od;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h40 + i);
            tick(took, od);
        end
        cmp_cnt++; if (count !== 3'd3) begin fail_cnt++; $display("FAIL flush_count_pre got=%0d want=3", count); end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h4F;
        #1;
        cmp_cnt++; if (in_ready !== 1'b0) begin fail_cnt++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        tick(took, od);
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        cmp_cnt++; if (count !== 3'd0) begin fail_cnt++; $display("FAIL flush_count got=%0d want=0", count); end
        cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        cmp_cnt++; if (out_data !== 8'h34) begin fail_cnt++; $display("FAIL flush_data_kept got=%h want=34", out_data); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(took, od);
            cmp_cnt++; if (took !== 1'b0) begin fail_cnt++; $display("FAIL flush_ghost k=%0d got=%h", k, od); end
        end
    endtask

    task automatic test_rst_mid();
        logic took; logic [7:0] od; logic [7:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h50 + i);
            tick(took, od);
        end
        in_valid = 1'b0;
        tick(took, od);
        tick(took, od);
        cmp_cnt++; if (count !== 3'd2) begin fail_cnt++; $display("FAIL rmid_count_pre got=%0d want=2", count); end
        cmp_cnt++; if (out_valid !== 1'b1) begin fail_cnt++; $display("FAIL rmid_out_valid_pre got=%b want=1", out_valid); end
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5F;
        #1;
        cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
        tick(took, od);
        rst = 1'b0; in_valid = 1'b0;
        sb.delete();
        cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
        cmp_cnt++; if (out_data !== 8'h00) begin fail_cnt++; $display("FAIL rmid_out_data got=%h want=00", out_data); end
        cmp_cnt++; if (count !== 3'd0) begin fail_cnt++; $display("FAIL rmid_count got=%0d want=0", count); end
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        tick(took, od);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cmp_cnt++; if (out_valid !== (c == 3)) begin fail_cnt++; $display("FAIL rmid_latency c=%0d got=%b want=%b", c, out_valid, (c == 3)); end
            tick(took, od);
            if (took) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                cmp_cnt++; if (od !== exp) begin fail_cnt++; $display("FAIL rmid_data got=%h want=%h", od, exp); end
            end
        end
        cmp_cnt++; if (sb.size() != 0) begin fail_cnt++; $display("FAIL rmid_drained left=%0d want=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_full_thru();
        test_flush();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached compared=%0d", cmp_cnt);
        $fatal(1, "watchdog");
    end

endmodule
